// File: rtl/maxnet_iterator.sv
// maxnet_iterator: iterative winner-take-all (Maxnet) lateral-inhibition engine.
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   start                 load request, honoured only in IDLE
//   in0..in3              signed initial scores, negative values load as zero
//   dec_done              decoder flag: exactly one of a0..a3 is nonzero
//   a0..a3                registered current scores, never negative
//   busy, done, fail      iterating / one-cycle completion pulse / no-winner result
//   iter_cnt              updates applied in the current or last run
module maxnet_iterator #(
    parameter int EPS_SHIFT = 3,
    parameter int MAX_ITER  = 255,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      in0,
    input  logic [31:0]      in1,
    input  logic [31:0]      in2,
    input  logic [31:0]      in3,
    input  logic             dec_done,
    output logic [31:0]      a0,
    output logic [31:0]      a1,
    output logic [31:0]      a2,
    output logic [31:0]      a3,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [CNT_W-1:0] iter_cnt
);
    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
    state_t state_q, state_d;
    logic [3:0][31:0] a_q, a_d, upd, ld, in_w;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic fail_q, fail_d, busy_q, done_q;
    assign in_w = {in3, in2, in1, in0};
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [33:0] s;
        logic [34:0] d;
        assign s = 34'(a_q[(i + 1) % 4]) + 34'(a_q[(i + 2) % 4]) + 34'(a_q[(i + 3) % 4]);
        assign d = {3'b000, a_q[i]} - {1'b0, s >> EPS_SHIFT};
        // d never exceeds a_q[i], so bits 33:32 are nonzero only when d is negative
        assign upd[i] = (d[34] | (|d[33:32])) ? '0 : d[31:0];
        assign ld[i] = in_w[i][31] ? '0 : in_w[i];
    end
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        fail_d  = fail_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && start) begin
            a_d     = ld;
            cnt_d   = '0;
            fail_d  = 1'b0;
            state_d = ITER;
        end else if (state_q == ITER) begin
            if (dec_done) begin
                fail_d  = 1'b0;
                state_d = DONE;
            end else if (a_q == '0 || cnt_q == CNT_W'(MAX_ITER)) begin
                fail_d  = 1'b1;
                state_d = DONE;
            end else begin
                a_d   = upd;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            cnt_q   <= '0;
            fail_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
            busy_q  <= (state_d == ITER);
            done_q  <= (state_d == DONE);
        end
    end
    assign {a3, a2, a1, a0} = a_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign fail     = fail_q;
    assign iter_cnt = cnt_q;
endmodule
